// File: rtl/pipe_skid_reg_pkg.sv
// ============================================================================
// Module   : pipe_skid_reg_pkg
// Brief    : Shared types and constants for the elastic pipeline stage register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_skid_reg_pkg;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_BUSY  = 2'b01,
    SKID_FULL  = 2'b10
  } skid_state_t;

  localparam int SKID_DEPTH = 2;

  function automatic logic [1:0] skid_occupancy(input skid_state_t s);
    case (s)
      SKID_BUSY: return 2'd1;
      SKID_FULL: return 2'(SKID_DEPTH);
      default:   return 2'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/flop_en_arn.sv
// ============================================================================
// Module   : flop_en_arn
// Brief    : WIDTH-bit register with enable, synchronous clear (wins over
//            enable) and asynchronous active-low reset to zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module flop_en_arn #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/pipe_skid_reg.sv
// ============================================================================
// Module   : pipe_skid_reg
// Brief    : Two-entry elastic stage register; up_ready_o is decoded from
//            state flops only, cutting the stall path between stages.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_n,
  input  logic             flush_i,
  input  logic             up_valid_i,
  input  logic [WIDTH-1:0] up_data_i,
  output logic             up_ready_o,
  output logic             dn_valid_o,
  output logic [WIDTH-1:0] dn_data_o,
  input  logic             dn_ready_i,
  output logic [1:0]       occupancy_o
);

  skid_state_t      r_state;
  skid_state_t      w_next_state;
  logic             w_push;
  logic             w_pop;
  logic             w_main_en;
  logic             w_skid_en;
  logic             w_main_from_skid;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_main_q;
  logic [WIDTH-1:0] w_skid_q;

  assign up_ready_o  = (r_state != SKID_FULL);
  assign dn_valid_o  = (r_state != SKID_EMPTY);
  assign occupancy_o = skid_occupancy(r_state);
  assign dn_data_o   = w_main_q;

  assign w_push = up_valid_i & up_ready_o;
  assign w_pop  = dn_valid_o & dn_ready_i;

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= SKID_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state     = r_state;
    w_main_en        = 1'b0;
    w_skid_en        = 1'b0;
    w_main_from_skid = 1'b0;
    case (r_state)
      SKID_EMPTY: begin
        if (w_push) begin
          w_next_state = SKID_BUSY;
          w_main_en    = 1'b1;
        end
      end
      SKID_BUSY: begin
        case ({w_push, w_pop})
          2'b11: w_main_en = 1'b1;
          2'b10: begin
            w_next_state = SKID_FULL;
            w_skid_en    = 1'b1;
          end
          2'b01: w_next_state = SKID_EMPTY;
          default: w_next_state = SKID_BUSY;
        endcase
      end
      SKID_FULL: begin
        // up_ready_o is low here, so the only movement is skid -> main.
        if (w_pop) begin
          w_next_state     = SKID_BUSY;
          w_main_en        = 1'b1;
          w_main_from_skid = 1'b1;
        end
      end
      default: w_next_state = SKID_EMPTY;
    endcase
    // Flush overrides everything; register contents are cleared via i_clr.
    if (flush_i) begin
      w_next_state = SKID_EMPTY;
    end
  end

  assign w_main_d = w_main_from_skid ? w_skid_q : up_data_i;

  flop_en_arn #(.WIDTH(WIDTH)) u_main (
    .clk_i   (clk_i),
    .reset_n (reset_n),
    .i_en    (w_main_en),
    .i_clr   (flush_i),
    .i_d     (w_main_d),
    .o_q     (w_main_q)
  );

  flop_en_arn #(.WIDTH(WIDTH)) u_skid (
    .clk_i   (clk_i),
    .reset_n (reset_n),
    .i_en    (w_skid_en),
    .i_clr   (flush_i),
    .i_d     (up_data_i),
    .o_q     (w_skid_q)
  );

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
// ============================================================================
// Module   : tb_pipe_skid_reg
// Brief    : Directed vector table, hand sequences and a random back-pressure
//            scoreboard run for pipe_skid_reg.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_skid_reg;

  localparam int WIDTH = 32;

  logic             clk_i = 1'b0;
  logic             reset_n = 1'b0;
  logic             flush_i = 1'b0;
  logic             up_valid_i = 1'b0;
  logic [WIDTH-1:0] up_data_i = '0;
  logic             up_ready_o;
  logic             dn_valid_o;
  logic [WIDTH-1:0] dn_data_o;
  logic             dn_ready_i = 1'b0;
  logic [1:0]       occupancy_o;

  int n_cmp = 0;
  int n_fail = 0;

  pipe_skid_reg #(.WIDTH(WIDTH)) dut (
    .clk_i       (clk_i),
    .reset_n     (reset_n),
    .flush_i     (flush_i),
    .up_valid_i  (up_valid_i),
    .up_data_i   (up_data_i),
    .up_ready_o  (up_ready_o),
    .dn_valid_o  (dn_valid_o),
    .dn_data_o   (dn_data_o),
    .dn_ready_i  (dn_ready_i),
    .occupancy_o (occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        flush;
    logic        uv;
    logic [31:0] ud;
    logic        dr;
    logic        e_ur;
    logic        e_dv;
    logic [31:0] e_dd;
    logic [1:0]  e_occ;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic ur, input logic dv,
                         input logic [31:0] dd, input logic [1:0] occ);
    chk({name, ".up_ready"}, 32'(up_ready_o), 32'(ur));
    chk({name, ".dn_valid"}, 32'(dn_valid_o), 32'(dv));
    chk({name, ".dn_data"}, dn_data_o, dd);
    chk({name, ".occ"}, 32'(occupancy_o), 32'(occ));
  endtask

  task automatic step(input logic fl, input logic uv, input logic [31:0] ud, input logic dr);
    flush_i    = fl;
    up_valid_i = uv;
    up_data_i  = ud;
    dn_ready_i = dr;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    flush_i = 1'b0; up_valid_i = 1'b0; up_data_i = '0; dn_ready_i = 1'b0;
    @(negedge clk_i);
    reset_n = 1'b1;
    @(negedge clk_i);
  endtask

  // Upstream must hold a stalled word until it is accepted.
  logic        r_pend = 1'b0;
  logic [31:0] r_pend_data = '0;
  always @(posedge clk_i) begin
    if (reset_n && r_pend) begin
      n_cmp++;
      assert (up_valid_i && up_data_i == r_pend_data)
      else begin
        n_fail++;
        $display("FAIL upstream_hold: got v=%0b d=%h expected v=1 d=%h",
                 up_valid_i, up_data_i, r_pend_data);
      end
    end
    r_pend      <= reset_n && up_valid_i && !up_ready_o && !flush_i;
    r_pend_data <= up_data_i;
  end

  initial begin
    //        fl  uv  ud      dr  ur  dv  dd      occ
    vecs[0]  = '{0, 1, 32'h1, 1, 1, 1, 32'h1, 2'd1};
    vecs[1]  = '{0, 1, 32'h2, 1, 1, 1, 32'h2, 2'd1};
    vecs[2]  = '{0, 1, 32'h3, 0, 0, 1, 32'h2, 2'd2};
    vecs[3]  = '{0, 1, 32'h4, 0, 0, 1, 32'h2, 2'd2};
    vecs[4]  = '{0, 1, 32'h4, 1, 1, 1, 32'h3, 2'd1};
    vecs[5]  = '{0, 1, 32'h4, 0, 0, 1, 32'h3, 2'd2};
    vecs[6]  = '{0, 0, 32'h0, 1, 1, 1, 32'h4, 2'd1};
    vecs[7]  = '{0, 0, 32'h0, 1, 1, 0, 32'h4, 2'd0};
    vecs[8]  = '{0, 0, 32'h0, 0, 1, 0, 32'h4, 2'd0};
    vecs[9]  = '{0, 1, 32'h5, 0, 1, 1, 32'h5, 2'd1};
    vecs[10] = '{0, 0, 32'h0, 0, 1, 1, 32'h5, 2'd1};
    vecs[11] = '{0, 1, 32'h6, 0, 0, 1, 32'h5, 2'd2};
    vecs[12] = '{1, 1, 32'h7, 1, 1, 0, 32'h0, 2'd0};
    vecs[13] = '{0, 1, 32'h8, 1, 1, 1, 32'h8, 2'd1};
    vecs[14] = '{1, 0, 32'h0, 0, 1, 0, 32'h0, 2'd0};
    vecs[15] = '{1, 1, 32'h9, 1, 1, 0, 32'h0, 2'd0};

    // Reset state
    #3;
    chk_out("reset", 1'b1, 1'b0, 32'h0, 2'd0);
    do_reset();

    // Vector table
    for (int i = 0; i < 16; i++) begin
      step(vecs[i].flush, vecs[i].uv, vecs[i].ud, vecs[i].dr);
      chk_out($sformatf("vec%0d", i), vecs[i].e_ur, vecs[i].e_dv, vecs[i].e_dd, vecs[i].e_occ);
    end

    // Reset mid-FULL, checked before any clock edge
    do_reset();
    step(0, 1, 32'hA, 0);
    step(0, 1, 32'hB, 0);
    chk_out("fill_ab", 1'b0, 1'b1, 32'hA, 2'd2);
    up_valid_i = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk_out("async_reset", 1'b1, 1'b0, 32'h0, 2'd0);
    @(negedge clk_i);
    reset_n = 1'b1;
    @(negedge clk_i);

    // Streaming, no bubbles
    for (int k = 1; k <= 8; k++) begin
      step(0, 1, 32'(k), 1);
      chk_out($sformatf("stream%0d", k), 1'b1, 1'b1, 32'(k), 2'd1);
    end
    step(0, 0, 32'h0, 1);
    chk_out("stream_drain", 1'b1, 1'b0, 32'h8, 2'd0);

    // Stall into skid, then release in order
    step(0, 1, 32'h10, 0);
    chk_out("stall1", 1'b1, 1'b1, 32'h10, 2'd1);
    step(0, 1, 32'h20, 0);
    chk_out("stall2", 1'b0, 1'b1, 32'h10, 2'd2);
    step(0, 1, 32'h30, 0);
    chk_out("stall3", 1'b0, 1'b1, 32'h10, 2'd2);
    step(0, 1, 32'h30, 1);
    chk_out("release1", 1'b1, 1'b1, 32'h20, 2'd1);
    step(0, 1, 32'h30, 1);
    chk_out("release2", 1'b1, 1'b1, 32'h30, 2'd1);
    step(0, 0, 32'h0, 1);
    chk_out("release3", 1'b1, 1'b0, 32'h30, 2'd0);

    // Flush from FULL with concurrent push and pop
    step(0, 1, 32'h40, 0);
    step(0, 1, 32'h50, 0);
    chk_out("pre_flush", 1'b0, 1'b1, 32'h40, 2'd2);
    step(1, 1, 32'h60, 1);
    chk_out("flush", 1'b1, 1'b0, 32'h0, 2'd0);
    step(0, 0, 32'h0, 1);
    chk_out("post_flush", 1'b1, 1'b0, 32'h0, 2'd0);

    // Random back-pressure with scoreboard
    begin
      logic [31:0] q[$];
      int          sent = 0;
      int          got = 0;
      int          cyc = 0;
      logic        offering = 1'b0;
      logic        prev_stall = 1'b0;
      logic [31:0] prev_data = '0;
      logic        b_push, b_pop;
      flush_i = 1'b0;
      while (got < 1000 && cyc < 20000) begin
        if (!offering && sent < 1000 && ($urandom_range(0, 3) != 0)) begin
          offering = 1'b1;
        end
        up_valid_i = offering;
        up_data_i  = 32'h1000 + 32'(sent);
        dn_ready_i = ($urandom_range(0, 2) != 0);
        @(negedge clk_i);
        if (prev_stall) begin
          chk("stall_valid", 32'(dn_valid_o), 32'h1);
          chk("stall_data", dn_data_o, prev_data);
        end
        if (!up_ready_o) chk("ready_low_occ", 32'(occupancy_o), 32'd2);
        b_push = up_valid_i & up_ready_o;
        b_pop  = dn_valid_o & dn_ready_i;
        if (b_pop) begin
          if (q.size() == 0) begin
            chk("sb_underflow", dn_data_o, 32'hFFFF_FFFF);
          end else begin
            chk("sb_order", dn_data_o, q.pop_front());
          end
          got++;
        end
        if (b_push) begin
          q.push_back(up_data_i);
          sent++;
          offering = 1'b0;
        end
        prev_stall = dn_valid_o & ~dn_ready_i;
        prev_data  = dn_data_o;
        @(posedge clk_i);
        #1;
        cyc++;
      end
      chk("random_done", 32'(got), 32'd1000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
